uart_tx_hamming: RTL
====================

// Module: uart_tx_hamming
// PURPOSE
//   Serialises 7-bit Hamming(7,4) codewords from the encoder stage onto a UART line.
//   Frame format: 1 start bit (0), 7 data bits LSB-first (code_in[0] first), STOP_BITS stop bits (1).
//   Sits directly downstream of the Hamming encoder; its code_out/valid_out drive code_in/code_valid.
//   A one-entry holding register absorbs the encoder's single-cycle valid pulse while a frame is shifting.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per UART bit period; legal range >= 2
//   STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//   clk         in   1  system clock, all state on rising edge
//   rst         in   1  asynchronous, active-high reset
//   ena         in   1  accept enable; when 0, code_valid is ignored
//   code_in     in   7  codeword, sampled when accepted
//   code_valid  in   1  codeword present this cycle (one-cycle pulse or level)
//   code_ready  out  1  = !hold_full; holding register can take a word
//   tx          out  1  serial line, idles high, registered output
//   busy        out  1  1 while a frame is on the line (state != IDLE)
//   overrun     out  1  one-cycle pulse: word offered while holding register full, word dropped
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): tx=1, busy=0, code_ready=1, overrun=0,
//     state=IDLE, hold_full=0, baud counter=0, bit index=0. Partial frame is abandoned.
//   Accept: edge where code_valid & ena & !hold_full -> hold_reg<=code_in, hold_full<=1.
//   Overrun: edge where code_valid & ena & hold_full -> word dropped; overrun=1 for next cycle.
//     This applies even when the FSM empties hold in the same edge (code_ready is not look-ahead).
//   ena=0 does not stop an in-flight frame or a pending held word; it only blocks acceptance.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE : hold_full -> load shifter from hold_reg, hold_full<=0, tx<=0, cnt<=0 -> START.
//     START: after CLKS_PER_BIT cycles -> tx<=shift[0], bit_idx<=0 -> DATA.
//     DATA : every CLKS_PER_BIT cycles shift right; after bit 6 period -> tx<=1 -> STOP.
//     STOP : lasts STOP_BITS*CLKS_PER_BIT cycles; at end, if hold_full -> load, tx<=0 -> START
//            (back-to-back, no idle gap); else tx stays 1 -> IDLE.
//   Latency: accepted at edge k -> tx low after edge k+1 (when IDLE at acceptance).
//   Frame length exactly (8+STOP_BITS)*CLKS_PER_BIT cycles; every bit exactly CLKS_PER_BIT cycles.
//   Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 at bit_tick;
//     reset to 0 on every frame load so start bit is full length.
//   Simultaneous accept + FSM load of a different word: legal only when hold empty at load;
//     hold drains on load edge, refills no earlier than the following edge.
//   busy=1 from the edge entering START until the edge returning to IDLE.
// STRUCTURE
//   Shared include uart_defs.vh: state encodings (IDLE/START/DATA/STOP), CODE_BITS=7,
//     START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1; reused by the matching receiver.
//   Sub-module uart_baud_gen (CLKS_PER_BIT): counter with sync clear, emits bit_tick pulse.
//   Top: holding register + FSM + 7-bit shifter + overrun flag.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//   Reset: rst=1 mid-DATA -> tx=1, busy=0, code_ready=1 immediately (async); no tx activity after release.
//   Single word: code_in=7'b1010011 pulse 1 cycle -> tx after 1 edge: 0,1,1,0,0,1,0,1,1, each 4 cycles; 36-cycle frame.
//   Back-to-back: 7'h55 then 7'h2A during first frame -> second start bit on cycle after first stop bit ends; busy stays 1.
//   Overrun: 3 words while frame 1 shifting -> 2nd held, 3rd dropped, overrun 1-cycle pulse; only 2 frames sent.
//   ena gating: code_valid=1 with ena=0 -> no accept, tx stays 1; ena dropped mid-frame -> frame completes.
//   STOP_BITS=2, CLKS_PER_BIT=16: 7'h7F -> 160-cycle frame, stop high for 32 cycles.

Source files
------------

// File: rtl/uart_tx_hamming_pkg.sv
// Shared definitions for the Hamming(7,4) UART transmitter and its matching receiver.
//   - tx_state_e : frame FSM states (idle, start bit, data bits, stop bits)
//   - CODE_BITS  : codeword width carried by one frame
//   - START_LEVEL / STOP_LEVEL / IDLE_LEVEL : line levels
package uart_tx_hamming_pkg;

    localparam int unsigned CODE_BITS = 7;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef logic [CODE_BITS-1:0] code_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_hamming_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   clr      : synchronous clear, holds the counter at 0
//   bit_tick : high during the last clock of each bit period
// The counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on bit_tick.
module uart_tx_hamming_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign bit_tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_hamming.sv
// UART serialiser for 7-bit Hamming(7,4) codewords.
// Frame: one start bit (0), 7 data bits LSB first, STOP_BITS stop bits (1).
// A one-entry holding register absorbs single-cycle valid pulses from the encoder
// while a frame is shifting; a word offered while it is full is dropped and flagged.
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   ena        : accept enable; code_valid is ignored while low
//   code_in    : codeword, captured when accepted
//   code_valid : codeword present this cycle
//   code_ready : holding register empty
//   tx         : serial line (registered, idles high)
//   busy       : a frame is on the line
//   overrun    : one-cycle pulse after a word was dropped
module uart_tx_hamming
    import uart_tx_hamming_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [CODE_BITS-1:0] code_in,
    input  logic                 code_valid,
    output logic                 code_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [2:0] LastDataIdx = 3'(CODE_BITS - 1);
    localparam logic [2:0] LastStopIdx = 3'(STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    code_t      hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    code_t      shift_q, shift_d;
    // Indexes data bits in StData and stop bits in StStop.
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       tx_q, tx_d;
    logic       overrun_q, overrun_d;

    logic       bit_tick;
    logic       load;
    logic       offer;
    logic       accept;

    assign offer  = code_valid & ena;
    assign accept = offer & ~hold_full_q;

    // Counter held at 0 while idle and restarted on every load so the start bit is full length.
    uart_tx_hamming_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (load || (state_q == StIdle)),
        .bit_tick(bit_tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load marks an edge that moves the held word into the shifter.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    state_d = StStart;
                    load    = 1'b1;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_tick && (bit_idx_q == LastDataIdx)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick && (bit_idx_q == LastStopIdx)) begin
                    // Back-to-back frames: no idle gap when a word is waiting.
                    if (hold_full_q) begin
                        state_d = StStart;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath / output next-state logic
    always_comb begin
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        if (load) begin
            shift_d   = hold_q;
            tx_d      = START_LEVEL;
            bit_idx_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_d = IDLE_LEVEL;
                end
                StStart: begin
                    if (bit_tick) begin
                        tx_d      = shift_q[0];
                        bit_idx_d = '0;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LastDataIdx) begin
                            tx_d      = STOP_LEVEL;
                            bit_idx_d = '0;
                        end else begin
                            shift_d   = shift_q >> 1;
                            tx_d      = shift_q[1];
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        bit_idx_d = (bit_idx_q == LastStopIdx) ? 3'd0 : bit_idx_q + 3'd1;
                    end
                end
                default: tx_d = IDLE_LEVEL;
            endcase
        end
    end

    // Holding register: load and accept are exclusive (load needs full, accept needs empty),
    // so a drained register refills no earlier than the following edge.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = code_in;
            hold_full_d = 1'b1;
        end
        // Uses the registered full flag: a word offered on the draining edge is still dropped.
        overrun_d = offer & hold_full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= IDLE_LEVEL;
            overrun_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign code_ready = ~hold_full_q;
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign overrun    = overrun_q;

endmodule
